// File: rtl/exc_sched.sv
// Exception / ERET sequencer: picks one MEM-stage event by priority, commits it
// to CP0, flushes the pipe for FLUSH_CYCLES cycles, then hands fetch a redirect.
module exc_sched #(
  parameter logic [31:0] EXC_VECTOR   = 32'hBFC00380,
  parameter int          FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        m_valid,
  input  logic [31:0] m_pc,
  input  logic        m_bd,
  input  logic        m_if_adel,
  input  logic        m_ri,
  input  logic        m_ov,
  input  logic        m_sys,
  input  logic        m_bp,
  input  logic        m_adel,
  input  logic        m_ades,
  input  logic [31:0] m_addr,
  input  logic        m_eret,
  input  logic        int_pending,
  input  logic        exl,
  input  logic [31:0] epc_in,
  output logic        exc_we,
  output logic [4:0]  exc_code,
  output logic        exc_epc_we,
  output logic [31:0] exc_epc,
  output logic        exc_bd,
  output logic        exc_bva_we,
  output logic [31:0] exc_bva,
  output logic        eret_we,
  output logic        flush,
  output logic        redir_valid,
  output logic [31:0] redir_pc,
  input  logic        redir_ready,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, FLUSH, REDIR} state_t;

  localparam logic [2:0] LAST_CNT = 3'(FLUSH_CYCLES - 1);

  state_t     state, state_nxt;
  logic [2:0] cnt, cnt_nxt;
  logic       any_exc;
  logic       take_exc;
  logic       event_det;
  logic [4:0] code_sel;
  logic       bva_we_sel;

  assign any_exc   = m_if_adel | m_ri | m_ov | m_sys | m_bp | m_adel | m_ades;
  assign take_exc  = int_pending | any_exc;
  assign event_det = (state == IDLE) & m_valid & ~stall & (take_exc | m_eret);

  // Architectural priority; ERET only wins when nothing else is raised.
  always_comb begin
    code_sel   = 5'd0;
    bva_we_sel = 1'b0;
    if (int_pending) begin
      code_sel = 5'd0;
    end else if (m_if_adel) begin
      code_sel   = 5'd4;
      bva_we_sel = 1'b1;
    end else if (m_ri) begin
      code_sel = 5'd10;
    end else if (m_ov) begin
      code_sel = 5'd12;
    end else if (m_sys) begin
      code_sel = 5'd8;
    end else if (m_bp) begin
      code_sel = 5'd9;
    end else if (m_adel) begin
      code_sel   = 5'd4;
      bva_we_sel = 1'b1;
    end else if (m_ades) begin
      code_sel   = 5'd5;
      bva_we_sel = 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (event_det) begin
          state_nxt = FLUSH;
          cnt_nxt   = 3'd0;
        end
      end
      FLUSH: begin
        if (cnt == LAST_CNT) begin
          state_nxt = REDIR;
          cnt_nxt   = 3'd0;
        end else begin
          cnt_nxt = cnt + 3'd1;
        end
      end
      REDIR: begin
        if (redir_ready) state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = 3'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 3'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      exc_we     <= 1'b0;
      eret_we    <= 1'b0;
      exc_code   <= 5'd0;
      exc_epc_we <= 1'b0;
      exc_epc    <= 32'd0;
      exc_bd     <= 1'b0;
      exc_bva_we <= 1'b0;
      exc_bva    <= 32'd0;
      redir_pc   <= 32'd0;
    end else begin
      exc_we  <= event_det & take_exc;
      eret_we <= event_det & ~take_exc;
      if (event_det) begin
        exc_code   <= code_sel;
        exc_epc_we <= ~exl;
        exc_epc    <= m_bd ? (m_pc - 32'd4) : m_pc;
        exc_bd     <= m_bd;
        exc_bva_we <= bva_we_sel;
        exc_bva    <= m_if_adel ? m_pc : m_addr;
        redir_pc   <= take_exc ? EXC_VECTOR : epc_in;
      end
    end
  end

  // Redirect handshake: redir_valid stays high with redir_pc stable until a
  // cycle where redir_valid & redir_ready; redir_ready is ignored otherwise.
  assign flush       = (state == FLUSH);
  assign redir_valid = (state == REDIR);
  assign busy        = (state != IDLE);

endmodule

// File: tb/tb_exc_sched.sv
// Bench for exc_sched: directed vector table, hand-written reset sequence, and
// randomized events checked against a priority-table reference model.
module tb_exc_sched;

  localparam logic [31:0] VEC = 32'hBFC00380;
  localparam int          FC  = 2;

  // event bit positions
  localparam int EV_INT = 0, EV_IFADEL = 1, EV_RI = 2, EV_OV = 3, EV_SYS = 4;
  localparam int EV_BP = 5, EV_ADEL = 6, EV_ADES = 7, EV_ERET = 8;

  typedef struct {
    logic [8:0]  ev;
    logic        bd;
    logic        exl;
    logic [31:0] pc;
    logic [31:0] addr;
    logic [31:0] epc_in;
    int          rdy_delay;
    int          stall_cyc;
    logic        inject;
    logic        x_exc;
    logic [4:0]  x_code;
    logic [31:0] x_epc;
    logic        x_epc_we;
    logic        x_bva_we;
    logic [31:0] x_bva;
    logic [31:0] x_target;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  logic stall, m_valid, m_bd, m_if_adel, m_ri, m_ov, m_sys, m_bp, m_adel, m_ades;
  logic m_eret, int_pending, exl, redir_ready;
  logic [31:0] m_pc, m_addr, epc_in;
  logic exc_we, exc_epc_we, exc_bd, exc_bva_we, eret_we, flush, redir_valid, busy;
  logic [4:0]  exc_code;
  logic [31:0] exc_epc, exc_bva, redir_pc;

  int n_cmp = 0;
  int n_err = 0;
  vec_t tbl[$];

  always #5 clk = ~clk;

  exc_sched #(.EXC_VECTOR(VEC), .FLUSH_CYCLES(FC)) dut (
    .clk(clk), .rst(rst), .stall(stall), .m_valid(m_valid), .m_pc(m_pc),
    .m_bd(m_bd), .m_if_adel(m_if_adel), .m_ri(m_ri), .m_ov(m_ov),
    .m_sys(m_sys), .m_bp(m_bp), .m_adel(m_adel), .m_ades(m_ades),
    .m_addr(m_addr), .m_eret(m_eret), .int_pending(int_pending), .exl(exl),
    .epc_in(epc_in), .exc_we(exc_we), .exc_code(exc_code),
    .exc_epc_we(exc_epc_we), .exc_epc(exc_epc), .exc_bd(exc_bd),
    .exc_bva_we(exc_bva_we), .exc_bva(exc_bva), .eret_we(eret_we),
    .flush(flush), .redir_valid(redir_valid), .redir_pc(redir_pc),
    .redir_ready(redir_ready), .busy(busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive_ev(input logic [8:0] ev);
    int_pending = ev[EV_INT];
    m_if_adel   = ev[EV_IFADEL];
    m_ri        = ev[EV_RI];
    m_ov        = ev[EV_OV];
    m_sys       = ev[EV_SYS];
    m_bp        = ev[EV_BP];
    m_adel      = ev[EV_ADEL];
    m_ades      = ev[EV_ADES];
    m_eret      = ev[EV_ERET];
  endtask

  // Reference: walk the cause list in priority order, first raised cause wins.
  function automatic vec_t model(input vec_t v);
    int          order[8] = '{EV_INT, EV_IFADEL, EV_RI, EV_OV, EV_SYS, EV_BP, EV_ADEL, EV_ADES};
    logic [4:0]  codes[8] = '{5'd0, 5'd4, 5'd10, 5'd12, 5'd8, 5'd9, 5'd4, 5'd5};
    logic        is_ad[8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    vec_t r = v;
    r.x_exc    = 1'b0;
    r.x_code   = 5'd0;
    r.x_bva_we = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (!r.x_exc && v.ev[order[i]]) begin
        r.x_exc    = 1'b1;
        r.x_code   = codes[i];
        r.x_bva_we = is_ad[i];
      end
    end
    r.x_epc    = v.bd ? v.pc - 32'd4 : v.pc;
    r.x_epc_we = ~v.exl;
    r.x_bva    = v.ev[EV_IFADEL] ? v.pc : v.addr;
    r.x_target = r.x_exc ? VEC : v.epc_in;
    return r;
  endfunction

  task automatic run_event(input vec_t v, input string tag);
    logic [31:0] pc_hold;
    @(negedge clk);
    m_valid = 1'b1; m_pc = v.pc; m_bd = v.bd; m_addr = v.addr;
    exl = v.exl; epc_in = v.epc_in; drive_ev(v.ev);
    redir_ready = (v.rdy_delay == 0);
    stall = (v.stall_cyc > 0);
    for (int s = 0; s < v.stall_cyc; s++) begin
      @(negedge clk);
      chk({tag, " stall_busy"}, 32'(busy), 32'd0);
      chk({tag, " stall_we"}, 32'(exc_we | eret_we), 32'd0);
    end
    stall = 1'b0;
    @(negedge clk);  // T+1
    if (v.inject) drive_ev(9'(1 << EV_RI));
    else begin m_valid = 1'b0; drive_ev(9'd0); end
    chk({tag, " exc_we"}, 32'(exc_we), 32'(v.x_exc));
    chk({tag, " eret_we"}, 32'(eret_we), 32'(!v.x_exc));
    chk({tag, " flush1"}, 32'(flush), 32'd1);
    chk({tag, " epc"}, exc_epc, v.x_epc);
    chk({tag, " bd"}, 32'(exc_bd), 32'(v.bd));
    chk({tag, " epc_we"}, 32'(exc_epc_we), 32'(v.x_epc_we));
    chk({tag, " bva_we"}, 32'(exc_bva_we), 32'(v.x_bva_we));
    if (v.x_exc) chk({tag, " code"}, 32'(exc_code), 32'(v.x_code));
    if (v.x_bva_we) chk({tag, " bva"}, exc_bva, v.x_bva);
    for (int i = 2; i <= FC; i++) begin
      @(negedge clk);
      chk({tag, " flush_n"}, 32'(flush), 32'd1);
      chk({tag, " pulse_once"}, 32'(exc_we | eret_we), 32'd0);
      chk({tag, " early_redir"}, 32'(redir_valid), 32'd0);
    end
    @(negedge clk);  // T+FC+1
    m_valid = 1'b0; drive_ev(9'd0);
    chk({tag, " flush_off"}, 32'(flush), 32'd0);
    chk({tag, " redir_valid"}, 32'(redir_valid), 32'd1);
    chk({tag, " redir_pc"}, redir_pc, v.x_target);
    pc_hold = redir_pc;
    for (int d = 1; d <= v.rdy_delay; d++) begin
      @(negedge clk);
      chk({tag, " hold_valid"}, 32'(redir_valid), 32'd1);
      chk({tag, " hold_pc"}, redir_pc, pc_hold);
      chk({tag, " hold_busy"}, 32'(busy), 32'd1);
    end
    redir_ready = 1'b1;
    @(negedge clk);
    chk({tag, " busy_done"}, 32'(busy), 32'd0);
    chk({tag, " redir_done"}, 32'(redir_valid), 32'd0);
    chk({tag, " epc_held"}, exc_epc, v.x_epc);
    redir_ready = 1'b0;
  endtask

  function automatic vec_t mk(input logic [8:0] ev, input logic bd, input logic exl_v,
                              input logic [31:0] pc, input logic [31:0] addr,
                              input logic [31:0] ein, input int dly, input int stl,
                              input logic inj);
    vec_t v;
    v = '{default: '0};
    v.ev = ev; v.bd = bd; v.exl = exl_v; v.pc = pc; v.addr = addr;
    v.epc_in = ein; v.rdy_delay = dly; v.stall_cyc = stl; v.inject = inj;
    return v;
  endfunction

  initial begin
    vec_t v;
    rst = 1'b1; stall = 1'b0; m_valid = 1'b0; m_pc = '0; m_bd = 1'b0; m_addr = '0;
    exl = 1'b0; epc_in = '0; redir_ready = 1'b0; drive_ev(9'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst exc_we", 32'(exc_we), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst redir_pc", redir_pc, 32'd0);
    chk("rst outs", 32'({exc_epc_we, exc_bd, exc_bva_we, eret_we, flush, redir_valid}), 32'd0);
    chk("rst data", exc_epc | exc_bva | 32'(exc_code), 32'd0);
    rst = 1'b0;

    // Directed table with hand-derived expectations.
    v = mk(9'(1 << EV_OV), 0, 0, 32'h80001000, 32'h0, 32'h0, 0, 0, 0);
    v.x_exc = 1; v.x_code = 12; v.x_epc = 32'h80001000; v.x_epc_we = 1;
    v.x_bva_we = 0; v.x_target = VEC; tbl.push_back(v);
    v = mk(9'(1 << EV_ADES), 1, 0, 32'h80002004, 32'h1002, 32'h0, 0, 0, 0);
    v.x_exc = 1; v.x_code = 5; v.x_epc = 32'h80002000; v.x_epc_we = 1;
    v.x_bva_we = 1; v.x_bva = 32'h1002; v.x_target = VEC; tbl.push_back(v);
    v = mk(9'(1 << EV_ERET), 0, 1, 32'h80004000, 32'h0, 32'h80003000, 1, 0, 0);
    v.x_exc = 0; v.x_epc = 32'h80004000; v.x_epc_we = 0;
    v.x_bva_we = 0; v.x_target = 32'h80003000; tbl.push_back(v);
    v = mk(9'((1 << EV_ERET) | (1 << EV_INT)), 0, 0, 32'h80004000, 32'h0, 32'h80003000, 0, 0, 0);
    v.x_exc = 1; v.x_code = 0; v.x_epc = 32'h80004000; v.x_epc_we = 1;
    v.x_bva_we = 0; v.x_target = VEC; tbl.push_back(v);
    v = mk(9'(1 << EV_SYS), 0, 1, 32'h80005000, 32'h0, 32'h0, 5, 0, 0);
    v.x_exc = 1; v.x_code = 8; v.x_epc = 32'h80005000; v.x_epc_we = 0;
    v.x_bva_we = 0; v.x_target = VEC; tbl.push_back(v);
    v = mk(9'(1 << EV_RI), 0, 0, 32'h80006000, 32'h0, 32'h0, 0, 3, 0);
    v.x_exc = 1; v.x_code = 10; v.x_epc = 32'h80006000; v.x_epc_we = 1;
    v.x_bva_we = 0; v.x_target = VEC; tbl.push_back(v);
    v = mk(9'(1 << EV_OV), 0, 0, 32'h80007000, 32'h0, 32'h0, 2, 0, 1);
    v.x_exc = 1; v.x_code = 12; v.x_epc = 32'h80007000; v.x_epc_we = 1;
    v.x_bva_we = 0; v.x_target = VEC; tbl.push_back(v);
    v = mk(9'((1 << EV_IFADEL) | (1 << EV_ADEL)), 1, 0, 32'h80008002, 32'h55, 32'h0, 0, 0, 0);
    v.x_exc = 1; v.x_code = 4; v.x_epc = 32'h80007FFE; v.x_epc_we = 1;
    v.x_bva_we = 1; v.x_bva = 32'h80008002; v.x_target = VEC; tbl.push_back(v);

    foreach (tbl[i]) run_event(tbl[i], $sformatf("vec%0d", i));

    // Reset in the middle of FLUSH, then a normal break.
    @(negedge clk);
    m_valid = 1'b1; m_pc = 32'h80009000; m_bd = 1'b0; exl = 1'b0; drive_ev(9'(1 << EV_OV));
    redir_ready = 1'b1;
    @(negedge clk);
    m_valid = 1'b0; drive_ev(9'd0);
    chk("rstseq exc_we", 32'(exc_we), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rstseq busy", 32'(busy), 32'd0);
    chk("rstseq flush", 32'(flush), 32'd0);
    chk("rstseq redir", 32'(redir_valid), 32'd0);
    chk("rstseq redir_pc", redir_pc, 32'd0);
    chk("rstseq data", exc_epc | 32'(exc_code), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rstseq quiet", 32'({redir_valid, exc_we, eret_we, busy}), 32'd0);
    end
    redir_ready = 1'b0;
    v = mk(9'(1 << EV_BP), 0, 0, 32'h8000A000, 32'h0, 32'h0, 0, 0, 0);
    v.x_exc = 1; v.x_code = 9; v.x_epc = 32'h8000A000; v.x_epc_we = 1;
    v.x_bva_we = 0; v.x_target = VEC;
    run_event(v, "bp_after_rst");

    // Randomized events against the reference model.
    for (int n = 0; n < 40; n++) begin
      logic [8:0] ev;
      ev = '0;
      for (int b = 0; b < 9; b++) ev[b] = ($urandom_range(0, 4) == 0);
      if (ev == 9'd0) ev[$urandom_range(0, 8)] = 1'b1;
      v = mk(ev, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             $urandom() & 32'hFFFF_FFFC, $urandom(), $urandom() & 32'hFFFF_FFFC,
             $urandom_range(0, 3), $urandom_range(0, 1), 1'($urandom_range(0, 1)));
      run_event(model(v), $sformatf("rnd%0d", n));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
